// File: rtl/tbox_gen.sv
// tbox_gen: N x N turn-based board with a K-in-a-row scanner (IDLE -> SCAN -> DONE).
// Optional one-level undo is compiled in when TBOX_GEN_UNDO_EN is defined.
module tbox_gen #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int CW = $clog2(N + 1),
  localparam int MW = $clog2(N * N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [CW-1:0]     row,
  input  logic [CW-1:0]     col,
  output logic              move_err,
  output logic [N*N-1:0]    valid,
  output logic [N*N-1:0]    symbol,
  output logic              turn,
  output logic [MW-1:0]     move_count,
  output logic [1:0]        game_state
`ifdef TBOX_GEN_UNDO_EN
  ,
  input  logic              undo
`endif
);

  localparam int NC  = N * N;
  localparam int IW  = $clog2(NC);
  localparam int LEN = 2 * K - 1;
  localparam int SCW = $clog2(LEN);
  localparam int RW  = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r;
  logic [NC-1:0]   valid_r;
  logic [NC-1:0]   symbol_r;
  logic            turn_r;
  logic            move_ready_r;
  logic            move_err_r;
  logic [MW-1:0]   count_r;
  logic [1:0]      gs_r;
  logic            place_sym_r;
  logic            win_r;
  logic [CW-1:0]   prow_r;
  logic [CW-1:0]   pcol_r;
  logic [1:0]      dir_r;
  logic [SCW-1:0]  idx_r;
  logic [RW-1:0]   run_r;
`ifdef TBOX_GEN_UNDO_EN
  logic [IW-1:0]   last_idx_r;
  logic            has_last_r;
`endif

  logic            in_range_s;
  logic [IW-1:0]   in_idx_s;
  logic            legal_s;
  int              dr_s;
  int              dc_s;
  int              off_s;
  int              r_s;
  int              c_s;
  logic            on_board_s;
  logic [IW-1:0]   scan_idx_s;
  logic            match_s;

  function automatic logic [IW-1:0] cell_index(input int r, input int c);
    cell_index = IW'((r - 32'sd1) * N + (c - 32'sd1));
  endfunction

  // Decode and legality check of the offered move.
  always_comb begin
    in_range_s = (row != {CW{1'b0}}) && (row <= CW'(N)) &&
                 (col != {CW{1'b0}}) && (col <= CW'(N));
    if (in_range_s) begin
      in_idx_s = cell_index(int'(row), int'(col));
    end else begin
      in_idx_s = {IW{1'b0}};
    end
    legal_s = in_range_s && !valid_r[in_idx_s] && (gs_r == 2'b00);
  end

  // Cell under inspection: placed cell plus offset along the current direction.
  always_comb begin
    case (dir_r)
      2'd0:    begin dr_s = 32'sd0; dc_s = 32'sd1;  end
      2'd1:    begin dr_s = 32'sd1; dc_s = 32'sd0;  end
      2'd2:    begin dr_s = 32'sd1; dc_s = 32'sd1;  end
      2'd3:    begin dr_s = 32'sd1; dc_s = -32'sd1; end
      default: begin dr_s = 32'sd0; dc_s = 32'sd0;  end
    endcase
    off_s = int'(idx_r) - (K - 1);
    r_s = int'(prow_r) + dr_s * off_s;
    c_s = int'(pcol_r) + dc_s * off_s;
    on_board_s = (r_s >= 32'sd1) && (r_s <= N) && (c_s >= 32'sd1) && (c_s <= N);
    if (on_board_s) begin
      scan_idx_s = cell_index(r_s, c_s);
    end else begin
      scan_idx_s = {IW{1'b0}};
    end
    match_s = on_board_s && valid_r[scan_idx_s] && (symbol_r[scan_idx_s] == place_sym_r);
  end

  // Controller: move acceptance, line scan and game result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      valid_r      <= {NC{1'b0}};
      symbol_r     <= {NC{1'b0}};
      turn_r       <= 1'b1;
      move_ready_r <= 1'b1;
      move_err_r   <= 1'b0;
      count_r      <= {MW{1'b0}};
      gs_r         <= 2'b00;
      place_sym_r  <= 1'b0;
      win_r        <= 1'b0;
      prow_r       <= {CW{1'b0}};
      pcol_r       <= {CW{1'b0}};
      dir_r        <= 2'd0;
      idx_r        <= {SCW{1'b0}};
      run_r        <= {RW{1'b0}};
`ifdef TBOX_GEN_UNDO_EN
      last_idx_r   <= {IW{1'b0}};
      has_last_r   <= 1'b0;
`endif
    end else begin
      move_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
`ifdef TBOX_GEN_UNDO_EN
          if (undo) begin
            if (has_last_r && (count_r != {MW{1'b0}})) begin
              valid_r[last_idx_r]  <= 1'b0;
              symbol_r[last_idx_r] <= 1'b0;
              count_r              <= count_r - MW'(1);
              turn_r               <= ~turn_r;
              gs_r                 <= 2'b00;
              has_last_r           <= 1'b0;
            end
          end else
`endif
          if (move_valid) begin
            if (legal_s) begin
              valid_r[in_idx_s]  <= 1'b1;
              symbol_r[in_idx_s] <= turn_r;
              count_r            <= count_r + MW'(1);
              turn_r             <= ~turn_r;
              place_sym_r        <= turn_r;
              prow_r             <= row;
              pcol_r             <= col;
              dir_r              <= 2'd0;
              idx_r              <= {SCW{1'b0}};
              run_r              <= {RW{1'b0}};
              win_r              <= 1'b0;
              state_r            <= SCAN;
              move_ready_r       <= 1'b0;
`ifdef TBOX_GEN_UNDO_EN
              last_idx_r         <= in_idx_s;
              has_last_r         <= 1'b1;
`endif
            end else begin
              move_err_r <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (match_s) begin
            if (run_r >= RW'(K - 1)) begin
              win_r <= 1'b1;
            end
            if (run_r != RW'(K)) begin
              run_r <= run_r + RW'(1);
            end
          end else begin
            run_r <= {RW{1'b0}};
          end
          // Last offset of a direction: the run restarts for the next one.
          if (idx_r == SCW'(LEN - 1)) begin
            idx_r <= {SCW{1'b0}};
            run_r <= {RW{1'b0}};
            dir_r <= dir_r + 2'd1;
            if (dir_r == 2'd3) begin
              state_r <= DONE;
            end
          end else begin
            idx_r <= idx_r + SCW'(1);
          end
        end
        DONE: begin
          if (win_r) begin
            gs_r <= place_sym_r ? 2'b01 : 2'b10;
          end else if (count_r == MW'(NC)) begin
            gs_r <= 2'b11;
          end else begin
            gs_r <= gs_r;
          end
          state_r      <= IDLE;
          move_ready_r <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          move_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign move_ready = move_ready_r;
  assign move_err   = move_err_r;
  assign valid      = valid_r;
  assign symbol     = symbol_r;
  assign turn       = turn_r;
  assign move_count = count_r;
  assign game_state = gs_r;

endmodule

// File: tb/tb_tbox_gen.sv
// Self-checking bench for tbox_gen: N=3/K=3 and N=5/K=4 instances against a board-level model.
// Exercises the undo path only when TBOX_GEN_UNDO_EN is defined.
module tb_tbox_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       mv_a, mv_b;
  logic [3:0] row_v, col_v;
`ifdef TBOX_GEN_UNDO_EN
  logic       undo_a, undo_b;
`endif

  logic       ready_a, err_a, turn_a;
  logic [8:0] valid_a, symbol_a;
  logic [3:0] count_a;
  logic [1:0] gs_a;
  logic        ready_b, err_b, turn_b;
  logic [24:0] valid_b, symbol_b;
  logic [4:0]  count_b;
  logic [1:0]  gs_b;

  tbox_gen #(.N(3), .K(3)) dut_a (
    .clk(clk), .reset(reset), .move_valid(mv_a), .move_ready(ready_a),
    .row(row_v[1:0]), .col(col_v[1:0]), .move_err(err_a), .valid(valid_a),
    .symbol(symbol_a), .turn(turn_a), .move_count(count_a), .game_state(gs_a)
`ifdef TBOX_GEN_UNDO_EN
    , .undo(undo_a)
`endif
  );

  tbox_gen #(.N(5), .K(4)) dut_b (
    .clk(clk), .reset(reset), .move_valid(mv_b), .move_ready(ready_b),
    .row(row_v[2:0]), .col(col_v[2:0]), .move_err(err_b), .valid(valid_b),
    .symbol(symbol_b), .turn(turn_b), .move_count(count_b), .game_state(gs_b)
`ifdef TBOX_GEN_UNDO_EN
    , .undo(undo_b)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;
  bit sel = 1'b0;
  int mn = 3, mk = 3;

  // Board-level model
  bit         m_occ [0:63];
  bit         m_sym [0:63];
  bit         m_turn;
  int         m_count;
  logic [1:0] m_gs, m_pend;
  int         m_busy;
  bit         m_err;
  int         m_last;
  bit         m_has_last;
  int         errs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit model_win(input bit s);
    int dr [4];
    int dc [4];
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    model_win = 1'b0;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        for (int d = 0; d < 4; d++) begin
          bit all;
          all = 1'b1;
          for (int i = 0; i < mk; i++) begin
            int rr, cc;
            rr = r + dr[d] * i;
            cc = c + dc[d] * i;
            if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) all = 1'b0;
            else if (!m_occ[rr*mn+cc] || m_sym[rr*mn+cc] != s) all = 1'b0;
          end
          if (all) model_win = 1'b1;
        end
  endfunction

  task automatic model_step();
    int r, c, ix;
    bit mv, un;
    mv = sel ? mv_b : mv_a;
    un = 1'b0;
`ifdef TBOX_GEN_UNDO_EN
    un = sel ? undo_b : undo_a;
`endif
    r = sel ? int'(row_v[2:0]) : int'(row_v[1:0]);
    c = sel ? int'(col_v[2:0]) : int'(col_v[1:0]);
    if (reset) begin
      for (int i = 0; i < 64; i++) begin m_occ[i] = 1'b0; m_sym[i] = 1'b0; end
      m_turn = 1'b1; m_count = 0; m_gs = 2'b00; m_busy = 0; m_err = 1'b0; m_has_last = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_gs = m_pend;
      end else if (un) begin
        if (m_has_last) begin
          m_occ[m_last] = 1'b0; m_count--; m_turn = ~m_turn; m_gs = 2'b00; m_has_last = 1'b0;
        end
      end else if (mv) begin
        if (r >= 1 && r <= mn && c >= 1 && c <= mn && m_gs == 2'b00 && !m_occ[(r-1)*mn+c-1]) begin
          ix = (r - 1) * mn + c - 1;
          m_occ[ix] = 1'b1; m_sym[ix] = m_turn; m_count++;
          m_last = ix; m_has_last = 1'b1;
          if (model_win(m_turn)) m_pend = m_turn ? 2'b01 : 2'b10;
          else if (m_count == mn * mn) m_pend = 2'b11;
          else m_pend = m_gs;
          m_turn = ~m_turn;
          m_busy = 4 * (2 * mk - 1) + 1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  // Per-cycle comparison of the active instance against the model.
  always @(negedge clk) begin : cmp
    logic [63:0] ev, es, av, as;
    if (chk_en) begin
      ev = '0; es = '0;
      for (int i = 0; i < mn * mn; i++) begin ev[i] = m_occ[i]; es[i] = m_occ[i] & m_sym[i]; end
      av = sel ? 64'(valid_b) : 64'(valid_a);
      as = sel ? 64'(symbol_b & valid_b) : 64'(symbol_a & valid_a);
      chk("valid", av, ev);
      chk("symbol", as, es);
      chk("turn", 64'(sel ? turn_b : turn_a), 64'(m_turn));
      chk("move_count", sel ? 64'(count_b) : 64'(count_a), 64'(m_count));
      chk("game_state", 64'(sel ? gs_b : gs_a), 64'(m_gs));
      chk("move_ready", 64'(sel ? ready_b : ready_a), 64'(m_busy == 0));
      chk("move_err", 64'(sel ? err_b : err_a), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy > 0 && n < 200) begin step(); n++; end
    if (m_busy > 0) chk("wait_idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic offer(input int r, input int c);
    wait_idle();
    row_v = 4'(r); col_v = 4'(c);
    if (sel) mv_b = 1'b1; else mv_a = 1'b1;
    step();
    mv_a = 1'b0; mv_b = 1'b0;
    errs += int'(sel ? err_b : err_a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic offer_timed(input int r, input int c, input int exp_low);
    int lowc;
    offer(r, c);
    lowc = 0;
    while (!ready_b && lowc < 100) begin lowc++; step(); end
    chk("ready_low_cycles", 64'(lowc), 64'(exp_low));
  endtask

  int draw_r [9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
  int draw_c [9] = '{1, 2, 3, 2, 1, 3, 2, 1, 3};
  int b_r [8] = '{1, 1, 5, 2, 1, 3, 5, 4};
  int b_c [8] = '{1, 4, 5, 3, 2, 2, 3, 1};

  initial begin
    reset = 1'b1; mv_a = 1'b0; mv_b = 1'b0; row_v = 4'd0; col_v = 4'd0; errs = 0;
`ifdef TBOX_GEN_UNDO_EN
    undo_a = 1'b0; undo_b = 1'b0;
`endif
    step();
    chk_en = 1'b1;
    do_reset();
    chk("reset_turn", 64'(turn_a), 64'd1);
    chk("reset_ready", 64'(ready_a), 64'd1);

    // Row win for X
    offer(1, 1); offer(2, 1); offer(1, 2); offer(2, 2); offer(1, 3);
    wait_idle();
    chk("row_win_state", 64'(gs_a), 64'd1);
    chk("row_win_count", 64'(count_a), 64'd5);
    errs = 0;
    offer(3, 3);
    chk("after_win_err", 64'(errs), 64'd1);
    step();
`ifdef TBOX_GEN_UNDO_EN
    undo_a = 1'b1; mv_a = 1'b1; row_v = 4'd3; col_v = 4'd3;
    step();
    chk("undo_cell", 64'(valid_a[2]), 64'd0);
    chk("undo_state", 64'(gs_a), 64'd0);
    chk("undo_turn", 64'(turn_a), 64'd1);
    chk("undo_count", 64'(count_a), 64'd4);
    step();
    undo_a = 1'b0; mv_a = 1'b0;
    chk("undo_twice_count", 64'(count_a), 64'd4);
    step();
`endif

    // Draw
    do_reset();
    for (int i = 0; i < 9; i++) offer(draw_r[i], draw_c[i]);
    wait_idle();
    chk("draw_state", 64'(gs_a), 64'd3);
    chk("draw_count", 64'(count_a), 64'd9);

    // Rejections, and moves offered while busy
    do_reset();
    errs = 0;
    offer(2, 2);
    row_v = 4'd1; col_v = 4'd1; mv_a = 1'b1;
    step(); step(); step();
    mv_a = 1'b0;
    offer(2, 2); offer(0, 1); offer(4, 1);
    step();
    chk("reject_errs", 64'(errs), 64'd3);
    chk("reject_turn", 64'(turn_a), 64'd0);
    chk("reject_count", 64'(count_a), 64'd1);

    // Reset together with a move
    wait_idle();
    row_v = 4'd3; col_v = 4'd3; mv_a = 1'b1; reset = 1'b1;
    step();
    mv_a = 1'b0; reset = 1'b0;
    chk("reset_vs_move_count", 64'(count_a), 64'd0);

    // Reset in the third scan cycle
    offer(1, 1);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midscan_valid", 64'(valid_a), 64'd0);
    chk("midscan_turn", 64'(turn_a), 64'd1);
    chk("midscan_ready", 64'(ready_a), 64'd1);
    chk("midscan_state", 64'(gs_a), 64'd0);
    step();

    // N=5, K=4: O anti-diagonal
    sel = 1'b1; mn = 5; mk = 4;
    do_reset();
    errs = 0;
    offer(6, 1);
    step();
    chk("b_range_err", 64'(errs), 64'd1);
    for (int i = 0; i < 8; i++) offer_timed(b_r[i], b_c[i], 29);
    chk("b_o_win_state", 64'(gs_b), 64'd2);
    chk("b_count", 64'(count_b), 64'd8);
    step(); step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
